// File: rtl/iir_biquad_cascade.sv
// Time-multiplexed cascade of direct-form-II biquads, one section per cycle, per-channel delay state.
// Optional IIR_SAT_EN: saturate w and section outputs instead of wrapping.
module iir_biquad_cascade #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int FRAC_W = 28,
    parameter int NSEC   = 3,
    parameter int NCH    = 4,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW    = $clog2(NSEC * 5)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              state_clr,
    output logic              sat_flag
);
    localparam int WW    = DATA_W + 2;
    localparam int PW    = DATA_W + COEF_W + 2;
    localparam int SW    = PW + 4;
    localparam int NST   = NSEC * NCH;
    localparam int NCOEF = NSEC * 5;
    localparam int SEC_W = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int IDX_W = (NST > 1) ? $clog2(NST) : 1;
    localparam logic signed [COEF_W-1:0] UNITY = {{(COEF_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state, state_nxt;

    logic [SEC_W-1:0]         sec;
    logic [CH_W-1:0]          ch;
    logic signed [DATA_W-1:0] x;
    logic signed [COEF_W-1:0] coef [NCOEF];
    logic signed [WW-1:0]     w1_mem [NST];
    logic signed [WW-1:0]     w2_mem [NST];

    logic [IDX_W-1:0]         sidx;
    logic [AW-1:0]            cb;
    logic signed [WW-1:0]     w1, w2;
    logic signed [COEF_W-1:0] b0, b1, b2, a1, a2;
    logic signed [PW-1:0]     p_a1, p_a2, p_b0, p_b1, p_b2;
    logic signed [SW-1:0]     w_acc, w_shf, y_acc, y_shf;
    logic signed [DATA_W-1:0] w_new, y_new;
    logic                     w_ovf, y_ovf, accept;

    function automatic logic ovf(input logic signed [SW-1:0] v);
        return v != SW'($signed(v[DATA_W-1:0]));
    endfunction

    function automatic logic [DATA_W-1:0] limit(input logic signed [SW-1:0] v);
`ifdef IIR_SAT_EN
        if (ovf(v))
            return v[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
        return v[DATA_W-1:0];
    endfunction

    // Section datapath for the (sec, ch) currently in flight
    always_comb begin
        sidx  = IDX_W'(int'(sec) * NCH + int'(ch));
        cb    = AW'(int'(sec) * 5);
        w1    = w1_mem[sidx];
        w2    = w2_mem[sidx];
        b0    = coef[cb];
        b1    = coef[cb + AW'(1)];
        b2    = coef[cb + AW'(2)];
        a1    = coef[cb + AW'(3)];
        a2    = coef[cb + AW'(4)];
        p_a1  = PW'(a1) * PW'(w1);
        p_a2  = PW'(a2) * PW'(w2);
        w_acc = (SW'(x) <<< FRAC_W) - SW'(p_a1) - SW'(p_a2);
        w_shf = w_acc >>> FRAC_W;
        w_ovf = ovf(w_shf);
        w_new = limit(w_shf);
        p_b0  = PW'(b0) * PW'(w_new);
        p_b1  = PW'(b1) * PW'(w1);
        p_b2  = PW'(b2) * PW'(w2);
        y_acc = SW'(p_b0) + SW'(p_b1) + SW'(p_b2);
        y_shf = y_acc >>> FRAC_W;
        y_ovf = ovf(y_shf);
        y_new = limit(y_shf);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) && !state_clr;
        out_valid = (state == HOLD);
        accept    = in_valid && in_ready;
        case (state)
            IDLE:    if (accept && int'(in_ch) < NCH) state_nxt = RUN;
            RUN:     if (int'(sec) == NSEC - 1) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NST; i++) begin
                w1_mem[i] <= '0;
                w2_mem[i] <= '0;
            end
            for (int i = 0; i < NCOEF; i++) coef[i] <= (i % 5 == 0) ? UNITY : '0;
            sec      <= '0;
            ch       <= '0;
            x        <= '0;
            out_data <= '0;
            out_ch   <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (state == IDLE && coef_we && int'(coef_addr) < NCOEF)
                coef[coef_addr] <= coef_data;
            if (state_clr) begin
                for (int i = 0; i < NST; i++) begin
                    w1_mem[i] <= '0;
                    w2_mem[i] <= '0;
                end
                sat_flag <= 1'b0;
            end else if (accept) begin
                x   <= in_data;
                ch  <= in_ch;
                sec <= '0;
            end else if (state == RUN) begin
                w1_mem[sidx] <= WW'(w_new);
                w2_mem[sidx] <= w1;
                x            <= y_new;
                sec          <= sec + SEC_W'(1);
                if (w_ovf || y_ovf) sat_flag <= 1'b1;
                if (int'(sec) == NSEC - 1) begin
                    out_data <= y_new;
                    out_ch   <= ch;
                end
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for iir_biquad_cascade (default parameters); expectations follow IIR_SAT_EN if defined.
module tb_iir_biquad_cascade;
    logic               clk = 1'b0;
    logic               reset, in_valid, in_ready, out_valid, out_ready;
    logic               coef_we, state_clr, sat_flag;
    logic signed [31:0] in_data, out_data;
    logic [1:0]         in_ch, out_ch;
    logic [3:0]         coef_addr;
    logic [31:0]        coef_data;
    int                 checks = 0, errors = 0;
    logic signed [31:0] y;
    logic [1:0]         yc;
    int                 lat;
    logic               seen;

    iir_biquad_cascade dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .state_clr(state_clr), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [31:0] d, input logic [1:0] c,
                        output logic signed [31:0] yo, output logic [1:0] yco, output int lo);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        in_data = d; in_ch = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lo = 0;
        while (!out_valid && lo < 20) begin tick(); lo++; end
        yo = out_data; yco = out_ch;
        tick();
    endtask

    task automatic run(input string tag, input logic signed [31:0] d, input logic [1:0] c,
                       input logic signed [31:0] exp);
        logic signed [31:0] r;
        logic [1:0]         rc;
        int                 l;
        send(d, c, r, rc, l);
        chk(tag, r, exp);
        chk({tag, "_ch"}, rc, c);
    endtask

    task automatic wcoef(input logic [3:0] a, input logic [31:0] d);
        coef_addr = a; coef_data = d; coef_we = 1'b1;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic clr();
        state_clr = 1'b1;
        tick();
        state_clr = 1'b0;
    endtask

    task automatic watch(input int n, output logic s);
        s = 1'b0;
        repeat (n) begin
            tick();
            if (out_valid) s = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_ch = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; state_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_sat_flag", sat_flag, 0);

        // Pass-through after reset, latency NSEC
        send(1000, 2'd0, y, yc, lat);
        chk("pass_data", y, 1000);
        chk("pass_ch", yc, 0);
        chk("pass_latency", lat, 3);

        // b0 = 0.5 in section 0
        wcoef(4'd0, 32'h0800_0000);
        run("half_gain", 4000, 2'd1, 2000);

        // Pole at 0.5 (a1 = -0.5)
        wcoef(4'd3, 32'hF800_0000);
        clr();
        run("imp_0", 32'sd1 <<< 20, 2'd0, 32'sd1 <<< 19);
        run("imp_1", 0, 2'd0, 32'sd1 <<< 18);
        run("imp_2", 0, 2'd0, 32'sd1 <<< 17);

        // Interleaved channels keep independent state
        clr();
        run("il_c0_0", 32'sd1 <<< 20, 2'd0, 32'sd1 <<< 19);
        run("il_c1_0", 0, 2'd1, 0);
        run("il_c0_1", 0, 2'd0, 32'sd1 <<< 18);
        run("il_c1_1", 32'sd1 <<< 20, 2'd1, 32'sd1 <<< 19);
        run("il_c0_2", 0, 2'd0, 32'sd1 <<< 17);
        run("il_c1_2", 0, 2'd1, 32'sd1 <<< 18);

        // Backpressure: HOLD keeps output, refuses input
        out_ready = 1'b0;
        in_data = 0; in_ch = 2'd0; in_valid = 1'b1;
        tick();
        in_data = 12345; in_ch = 2'd3;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        chk("hold_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_data", out_data, 32'sd1 <<< 16);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        watch(5, seen);
        chk("hold_no_extra_out", seen, 0);
        run("after_hold", 0, 2'd0, 32'sd1 <<< 15);

        // state_clr mid-RUN aborts and zeros state
        in_data = 32'sd1 <<< 20; in_ch = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clr();
        chk("clr_out_valid", out_valid, 0);
        watch(6, seen);
        chk("clr_no_out", seen, 0);
        run("clr_zero_state", 32'sd1 <<< 20, 2'd0, 32'sd1 <<< 19);

        // Asynchronous reset mid-RUN: sample dropped, coefficients back to pass-through
        in_data = 32'sd1 <<< 20; in_ch = 2'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        chk("rst_mid_out_valid", out_valid, 0);
        reset = 1'b0;
        watch(6, seen);
        chk("rst_no_out", seen, 0);
        run("rst_pass", 32'sd1 <<< 20, 2'd1, 32'sd1 <<< 20);
        run("rst_zero_state", 0, 2'd0, 0);

        // Overflow: b0 = 2.0 on full-scale input
        wcoef(4'd0, 32'h2000_0000);
`ifdef IIR_SAT_EN
        run("ovf_out", 32'sh7FFF_FFFF, 2'd2, 32'sh7FFF_FFFF);
`else
        run("ovf_out", 32'sh7FFF_FFFF, 2'd2, -2);
`endif
        chk("ovf_sat_flag", sat_flag, 1);
        clr();
        chk("ovf_flag_cleared", sat_flag, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
